// File: rtl/sweep_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
//   state_e      : sequencer states
//   vec_count()  : number of input vectors for an N_IN-input function
//   settle_w()   : width of the settle down-counter for a given SETTLE
package sweep_pkg;

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_e;

    localparam int DEF_N_IN   = 4;
    localparam int DEF_SETTLE = 1;
    localparam int DEF_VECS   = 1 << DEF_N_IN;

    function automatic int vec_count(input int n_in);
        return 1 << n_in;
    endfunction

    // Counter must hold SETTLE-1; keep at least one bit so SETTLE=1 still builds.
    function automatic int settle_w(input int settle);
        return (settle < 2) ? 1 : $clog2(settle + 1);
    endfunction

    localparam int DEF_CNT_W = settle_w(DEF_SETTLE);

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control/status and function-under-test bus of the truth-table sweeper.
//   start/abort/expected : sweep control from the bench or control register
//   dut_in/dut_y         : vector out to, result back from, the function under test
//   busy/done/pass       : sweep status
//   err_count/first_fail_idx/first_fail_valid : mismatch record of the current/last sweep
// slave  = sweeper side, master = controller/function side.
interface truth_table_sweeper_if
    import sweep_pkg::*;
#(
    parameter int N_IN = DEF_N_IN
);
    localparam int VECS = vec_count(N_IN);

    logic                 start;
    logic                 abort;
    logic [VECS-1:0]      expected;
    logic [N_IN-1:0]      dut_in;
    logic                 dut_y;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [N_IN:0]        err_count;
    logic [N_IN-1:0]      first_fail_idx;
    logic                 first_fail_valid;

    modport slave (
        input  start, abort, expected, dut_y,
        output dut_in, busy, done, pass, err_count, first_fail_idx, first_fail_valid
    );

    modport master (
        output start, abort, expected, dut_y,
        input  dut_in, busy, done, pass, err_count, first_fail_idx, first_fail_valid
    );

endinterface

// File: rtl/truth_table_sweeper_settle_timer.sv
// sweep_settle_timer: loadable down-counter that measures how long a vector
// has been held on dut_in before it may be sampled.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (wins over en)
//   load_val   : reload value (SETTLE-1)
//   en         : count down while non-zero
//   zero       : counter is at zero
module sweep_settle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)                   cnt_d = load_val;
        else if (en && cnt_q != '0) cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks every input vector of an N_IN-input combinational
// function, holds each for SETTLE cycles, compares dut_y against a latched
// expected truth table and records mismatch count and lowest failing vector.
//   clk, rst_n : clock, async active-low reset
//   bus        : truth_table_sweeper_if.slave (control, status, function-under-test I/O)
// All outputs are registered; done and pass appear on the edge that leaves DONE.
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int N_IN   = DEF_N_IN,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_sweeper_if.slave  bus
);
    localparam int VECS = vec_count(N_IN);
    localparam int IW   = N_IN + 1;   // one spare bit so the last vector never wraps
    localparam int CW   = settle_w(SETTLE);
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);
    localparam logic [IW-1:0] LAST   = IW'(VECS - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d, idx_inc;
    logic [VECS-1:0] exp_q, exp_d;
    logic [N_IN-1:0] dut_in_q, dut_in_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [IW-1:0]   err_q, err_d;
    logic [N_IN-1:0] ff_idx_q, ff_idx_d;
    logic            ff_vld_q, ff_vld_d;
    logic            tmr_load, tmr_zero, mismatch;

    assign idx_inc  = idx_q + IW'(1);
    assign mismatch = bus.dut_y ^ exp_q[idx_q[N_IN-1:0]];

    sweep_settle_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (RELOAD),
        .en       (state_q == S_DRIVE),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        exp_d    = exp_q;
        dut_in_d = dut_in_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        pass_d   = pass_q;
        err_d    = err_q;
        ff_idx_d = ff_idx_q;
        ff_vld_d = ff_vld_q;
        tmr_load = 1'b0;

        // Abort freezes the partial record and suppresses this cycle's sample.
        if (bus.abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        exp_d    = bus.expected;
                        idx_d    = '0;
                        dut_in_d = '0;
                        err_d    = '0;
                        ff_idx_d = '0;
                        ff_vld_d = 1'b0;
                        pass_d   = 1'b0;
                        tmr_load = 1'b1;
                        state_d  = S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (tmr_zero) state_d = S_SAMPLE;
                end
                S_SAMPLE: begin
                    if (mismatch) begin
                        err_d = err_q + IW'(1);
                        if (!ff_vld_q) begin
                            ff_idx_d = idx_q[N_IN-1:0];
                            ff_vld_d = 1'b1;
                        end
                    end
                    if (idx_q == LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d    = idx_inc;
                        dut_in_d = idx_inc[N_IN-1:0];
                        tmr_load = 1'b1;
                        state_d  = S_DRIVE;
                    end
                end
                S_DONE: begin
                    done_d  = 1'b1;
                    pass_d  = (err_q == '0);
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            exp_q    <= '0;
            dut_in_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            ff_idx_q <= '0;
            ff_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            exp_q    <= exp_d;
            dut_in_q <= dut_in_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            ff_idx_q <= ff_idx_d;
            ff_vld_q <= ff_vld_d;
        end
    end

    assign bus.dut_in           = dut_in_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.err_count        = err_q;
    assign bus.first_fail_idx   = ff_idx_q;
    assign bus.first_fail_valid = ff_vld_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: three instances (N_IN=3/SETTLE=1,
// N_IN=4/SETTLE=1, N_IN=4/SETTLE=3), each driving a table-defined function.
// Expected results come from a truth-table comparison model over the vectors.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // per-unit stimulus and observed outputs, padded to 4-input width
    logic [2:0]       start_s = '0, abort_s = '0;
    logic [2:0][15:0] exp_s   = '0;
    logic [2:0][15:0] fut_tab = '0;
    logic [2:0]       busy_o, done_o, pass_o, ffv_o;
    logic [2:0][4:0]  err_o;
    logic [2:0][3:0]  ffi_o, din_o;

    truth_table_sweeper_if #(.N_IN(3)) if0 ();
    truth_table_sweeper_if #(.N_IN(4)) if1 ();
    truth_table_sweeper_if #(.N_IN(4)) if2 ();

    truth_table_sweeper #(.N_IN(3), .SETTLE(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    truth_table_sweeper #(.N_IN(4), .SETTLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    truth_table_sweeper #(.N_IN(4), .SETTLE(3)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    assign if0.start = start_s[0]; assign if0.abort = abort_s[0]; assign if0.expected = exp_s[0][7:0];
    assign if1.start = start_s[1]; assign if1.abort = abort_s[1]; assign if1.expected = exp_s[1];
    assign if2.start = start_s[2]; assign if2.abort = abort_s[2]; assign if2.expected = exp_s[2];
    assign if0.dut_y = fut_tab[0][din_o[0]];
    assign if1.dut_y = fut_tab[1][din_o[1]];
    assign if2.dut_y = fut_tab[2][din_o[2]];

    assign busy_o = {if2.busy, if1.busy, if0.busy};
    assign done_o = {if2.done, if1.done, if0.done};
    assign pass_o = {if2.pass, if1.pass, if0.pass};
    assign ffv_o  = {if2.first_fail_valid, if1.first_fail_valid, if0.first_fail_valid};
    assign err_o  = {if2.err_count, if1.err_count, {1'b0, if0.err_count}};
    assign ffi_o  = {if2.first_fail_idx, if1.first_fail_idx, {1'b0, if0.first_fail_idx}};
    assign din_o  = {if2.dut_in, if1.dut_in, {1'b0, if0.dut_in}};

    function automatic int n_of(input int u); return (u == 0) ? 3 : 4; endfunction
    function automatic int s_of(input int u); return (u == 2) ? 3 : 1; endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: compare function table against mask over the first nsamp vectors.
    task automatic model(input logic [15:0] tab, input logic [15:0] mask, input int nsamp,
                         output int ec, output int ffi, output bit ffv);
        ec = 0; ffi = 0; ffv = 1'b0;
        for (int v = 0; v < nsamp; v++)
            if (tab[v] != mask[v]) begin
                ec++;
                if (!ffv) begin ffv = 1'b1; ffi = v; end
            end
    endtask

    task automatic chk_result(input string tag, input int u, input int ec, input int ffi,
                              input bit ffv, input bit pass_exp);
        chk({tag, "/err_count"}, 32'(err_o[u]), 32'(ec));
        chk({tag, "/ff_valid"},  32'(ffv_o[u]), 32'(ffv));
        chk({tag, "/ff_idx"},    32'(ffi_o[u]), 32'(ffi));
        chk({tag, "/pass"},      32'(pass_o[u]), 32'(pass_exp));
    endtask

    // Full sweep; hold keeps start high through the whole sweep including the DONE cycle.
    task automatic sweep(input string tag, input int u, input logic [15:0] mask, input bit hold);
        int vecs, per, lat, done_at, pulses, bad_in, ec, ffi, want;
        bit ffv;
        vecs = 1 << n_of(u);
        per  = s_of(u) + 1;
        lat  = 1 + vecs * per;
        model(fut_tab[u], mask, vecs, ec, ffi, ffv);
        @(negedge clk);
        exp_s[u]   = mask;
        start_s[u] = 1'b1;
        @(posedge clk); #1;                       // edge 0: start accepted
        if (!hold) start_s[u] = 1'b0;
        exp_s[u] = 16'($urandom);                 // must be ignored from here on
        chk({tag, "/busy"}, 32'(busy_o[u]), 32'd1);
        done_at = -1; pulses = 0; bad_in = (din_o[u] != 4'd0) ? 1 : 0;
        for (int n = 1; n <= lat + 1; n++) begin
            @(posedge clk); #1;
            want = n / per;
            if (want > vecs - 1) want = vecs - 1;
            if (int'(din_o[u]) != want) bad_in++;
            if (done_o[u]) begin pulses++; done_at = n; end
            if (n == lat) start_s[u] = 1'b0;
        end
        chk({tag, "/done_edge"},  32'(done_at), 32'(lat));
        chk({tag, "/done_count"}, 32'(pulses), 32'd1);
        chk({tag, "/dut_in_seq"}, 32'(bad_in), 32'd0);
        chk({tag, "/busy_end"},   32'(busy_o[u]), 32'd0);
        chk_result(tag, u, ec, ffi, ffv, ec == 0);
    endtask

    task automatic chk_reset(input string tag, input int u);
        chk({tag, "/busy"},   32'(busy_o[u]), 32'd0);
        chk({tag, "/done"},   32'(done_o[u]), 32'd0);
        chk({tag, "/dut_in"}, 32'(din_o[u]),  32'd0);
        chk_result(tag, u, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [15:0] t, m;
        logic [3:0]  vv;
        int ec, ffi, pulses, u;
        bit ffv;

        // ---- reset state
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk_reset($sformatf("reset_u%0d", k), k);
        @(negedge clk); rst_n = 1'b1;

        // ---- N_IN=3, Y = ~B
        t = '0;
        for (int v = 0; v < 8; v++) begin vv = 4'(v); t[v] = ~vv[1]; end
        fut_tab[0] = t;
        sweep("notb_33", 0, 16'h0033, 1'b0);
        sweep("notb_32", 0, 16'h0032, 1'b0);
        sweep("notb_cc", 0, 16'h00CC, 1'b1);

        // ---- N_IN=4 four-term function; its table also has vector 1011 set (A&C)
        t = '0;
        for (int v = 0; v < 16; v++) begin
            vv = 4'(v);
            t[v] = (vv[2] & vv[0]) | (vv[3] & vv[1]) | (vv[3] & vv[2]) | (~vv[2] & ~vv[0]);
        end
        fut_tab[1] = t;
        fut_tab[2] = t;
        sweep("f4_f5a5", 1, 16'hF5A5, 1'b0);
        sweep("f4_table", 1, t, 1'b0);
        sweep("f4_s3", 2, t, 1'b0);

        // ---- abort in IDLE: no effect on held results
        @(negedge clk); abort_s[1] = 1'b1;
        @(posedge clk); #1; abort_s[1] = 1'b0;
        chk("idle_abort/busy", 32'(busy_o[1]), 32'd0);
        chk("idle_abort/pass", 32'(pass_o[1]), 32'd1);

        // ---- abort at edge 10 with start held high
        m = 16'($urandom);
        model(fut_tab[1], m, 10 / 2, ec, ffi, ffv);
        @(negedge clk); exp_s[1] = m; start_s[1] = 1'b1;
        pulses = 0;
        for (int n = 0; n <= 10; n++) begin
            @(posedge clk); #1;
            if (done_o[1]) pulses++;
        end
        abort_s[1] = 1'b1;
        @(posedge clk); #1;                       // edge 11
        abort_s[1] = 1'b0;
        chk("abort/busy", 32'(busy_o[1]), 32'd0);
        chk("abort/done", 32'(pulses + int'(done_o[1])), 32'd0);
        chk_result("abort", 1, ec, ffi, ffv, 1'b0);
        @(posedge clk); #1;                       // edge 12: still-high start taken from IDLE
        chk("abort/restart", 32'(busy_o[1]), 32'd1);
        start_s[1] = 1'b0;
        abort_s[1] = 1'b1;
        @(posedge clk); #1; abort_s[1] = 1'b0;
        sweep("abort_resweep", 1, m, 1'b0);

        // ---- reset at edge 7 of a sweep
        m = ~fut_tab[1];
        @(negedge clk); exp_s[1] = m; start_s[1] = 1'b1;
        @(posedge clk); #1; start_s[1] = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("pre_reset/err", 32'(err_o[1]), 32'd3);
        rst_n = 1'b0;
        #1;
        chk_reset("mid_reset", 1);
        @(negedge clk); rst_n = 1'b1;
        sweep("post_reset", 1, m, 1'b0);

        // ---- randomized tables and masks (sparse or no errors)
        for (int i = 0; i < 8; i++) begin
            u = int'($urandom_range(0, 2));
            fut_tab[u] = 16'($urandom);
            m = fut_tab[u] ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            if (i % 3 == 0) m = fut_tab[u];
            sweep($sformatf("rand%0d_u%0d", i, u), u, m, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
